logic_unit_arbiter: RTL
=======================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters:
//  req0 = EX-stage ALU path, req1 = branch-compare/secondary issue path.
//  Round-robin arbitration with valid/ready handshakes on both sides.
//  One registered output stage: 1-cycle latency, 1 op/cycle sustained throughput.
// PARAMETERS
//  WIDTH   32  operand/result width
//  TAG_W   4   opaque requester tag, returned with the result
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high
//  flush       in   1        pipeline flush: drop the in-flight result, accept nothing this cycle
//  req_valid   in   2        per-requester op valid ([0]=EX, [1]=secondary)
//  req_ready   out  2        per-requester accept
//  req_op      in   2x2      {req_op1,req_op0}: 00 AND, 01 OR, 10 XOR, 11 NOR
//  req_a       in   2xWIDTH  operand A per requester
//  req_b       in   2xWIDTH  operand B per requester
//  req_tag     in   2xTAG_W  tag per requester
//  resp_valid  out  1        result register holds a valid result
//  resp_ready  in   1        consumer accepts the result
//  resp_data   out  WIDTH    op(A,B)
//  resp_id     out  1        requester that issued this result
//  resp_tag    out  TAG_W    tag of that request
// BEHAVIOUR
//  - Reset (sync): resp_valid=0, resp_data=0, resp_id=0, resp_tag=0, rr_last=1.
//    rr_last=1 means req0 wins the first tie.
//  - can_accept = !flush && (!resp_valid || resp_ready).
//  - Grant (combinational):
//    * only one req_valid set -> that requester;
//    * both set -> requester != rr_last;
//    * none -> no grant.
//  - req_ready[i] = grant[i] && can_accept. At most one bit of req_ready is high.
//  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
//  - A requester holds op/a/b/tag stable while valid && !ready.
//  - Transfer on req_valid[i] && req_ready[i]. Next edge:
//    resp_valid=1, resp_data=op(a,b), resp_id=i, resp_tag=tag[i], rr_last=i.
//  - No transfer but resp_ready && resp_valid -> resp_valid=0.
//    resp_data/id/tag hold their values (don't-care once resp_valid=0).
//  - Drain and accept in the same cycle is legal: no bubble, full throughput.
//  - Backpressure (resp_valid && !resp_ready):
//    * req_ready=00;
//    * resp_* held bit-stable;
//    * rr_last unchanged.
//  - flush=1: req_ready=00 and resp_valid=0 at next edge regardless of resp_ready.
//    rr_last unchanged; flush has priority over every other event.
//  - reset has priority over flush. Reset mid-op drops the held result; no response is emitted.
//  - Widths: all ops are purely bitwise, no carry, no sign handling.
//    NOR = ~(a|b) across the full WIDTH.
//  - The requester that is not granted is not starved: with both valid and
//    continuous acceptance, grants strictly alternate.
// STRUCTURE
//  - Package logic_arb_pkg:
//    * opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
//    * default WIDTH and TAG_W.
//  - Sub-module logic_unit32: purely combinational (a, b, op) -> y, one instance.
//    Built from per-bit gate primitives; no state.
//  - The arbiter holds the grant logic, rr_last, the output register and the handshake logic.
// TESTING
//  1. After reset: resp_valid=0, req_ready=00 with no valid.
//     Both valid in cycle 1 -> req_ready=01 (req0 wins).
//  2. req0 AND a=F0F0F0F0 b=FF00FF00 tag=3 -> next cycle:
//     resp_valid=1, data=F000F000, id=0, tag=3.
//  3. req1 NOR a=00000000 b=FFFF0000 -> data=0000FFFF.
//     Then XOR a=AAAAAAAA b=FFFFFFFF -> 55555555.
//  4. Both valid for 6 cycles, resp_ready=1 -> grants 0,1,0,1,0,1.
//     One result per cycle; tags are returned in grant order.
//  5. Backpressure: hold resp_ready=0 for 3 cycles with both valid -> req_ready=00,
//     resp_* stable. Then set resp_ready=1 -> drain and next accept in the same cycle.
//  6. flush with a valid result and resp_ready=0 -> resp_valid=0 next cycle, no accept,
//     rr_last kept. Repeat with reset asserted mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// Shared constants and types for the two-requester logic-unit arbiter.
// Opcode encodings and default datapath widths live here.
package logic_arb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int TAG_W_DEF = 4;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_NOR = 2'b11;

endpackage

// File: rtl/logic_unit32.sv
// Combinational bitwise logic unit: per-bit gates, then an opcode select.
// No carry chain and no state; every bit is independent.
module logic_unit32
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_and;
    logic [WIDTH-1:0] y_or;
    logic [WIDTH-1:0] y_xor;
    logic [WIDTH-1:0] y_nor;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and u_and (y_and[i], a[i], b[i]);
        or  u_or  (y_or[i],  a[i], b[i]);
        xor u_xor (y_xor[i], a[i], b[i]);
        nor u_nor (y_nor[i], a[i], b[i]);
    end

    always_comb begin
        y = y_and;
        unique case (1'b1)
            (op == OP_AND): y = y_and;
            (op == OP_OR):  y = y_or;
            (op == OP_XOR): y = y_xor;
            (op == OP_NOR): y = y_nor;
            default:        y = y_and;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logic unit between the EX path (req0) and the
// secondary issue path (req1), with a single registered result stage.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][1:0]            req_op,
    input  logic [1:0][WIDTH-1:0]      req_a,
    input  logic [1:0][WIDTH-1:0]      req_b,
    input  logic [1:0][TAG_W-1:0]      req_tag,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       resp_id,
    output logic [TAG_W-1:0]           resp_tag
);

    logic             rr_last;
    logic [1:0]       grant;
    logic             can_accept;
    logic             xfer;
    logic             sel;
    op_t              op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] y;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (req_valid == 2'b01): grant = 2'b01;
            (req_valid == 2'b10): grant = 2'b10;
            (req_valid == 2'b11): grant = rr_last ? 2'b01 : 2'b10;
            default:              grant = 2'b00;
        endcase
    end

    // Reset is gated in too, so nothing is handed over into a cleared stage.
    assign can_accept = !reset && !flush && (!resp_valid || resp_ready);
    assign req_ready  = grant & {2{can_accept}};
    assign xfer       = |req_ready;
    assign sel        = req_ready[1];

    assign op_sel = req_op[sel];
    assign a_sel  = req_a[sel];
    assign b_sel  = req_b[sel];

    logic_unit32 #(
        .WIDTH (WIDTH)
    ) u_lu (
        .a  (a_sel),
        .b  (b_sel),
        .op (op_sel),
        .y  (y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_tag   <= '0;
            rr_last    <= 1'b1;
        end else if (flush) begin
            resp_valid <= 1'b0;
        end else if (xfer) begin
            resp_valid <= 1'b1;
            resp_data  <= y;
            resp_id    <= sel;
            resp_tag   <= req_tag[sel];
            rr_last    <= sel;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule
